// File: rtl/edit_sequencer.sv
// rtl/edit_sequencer.sv - front-panel key debounce, screen/edit sequencing and Plus/Minus conditioning
// Optional auto-repeat of held Plus/Minus in edit mode: define EDIT_AUTO_REPEAT_EN.
module edit_sequencer #(
  parameter int DEBOUNCE      = 16,
  parameter int HOLD_CYCLES   = 512,
  parameter int REPEAT_CYCLES = 64,
  parameter int BLINK_HALF    = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       KeyScreen,
  input  logic       KeyEdit,
  input  logic       KeyNext,
  input  logic       KeyPlus,
  input  logic       KeyMinus,
  output logic [1:0] screen,
  output logic       EditMode,
  output logic [2:0] EditPos,
  output logic       KeyPlusOut,
  output logic       KeyMinusOut,
  output logic       Blink
);

  localparam int K_SCREEN = 0;
  localparam int K_EDIT   = 1;
  localparam int K_NEXT   = 2;
  localparam int K_PLUS   = 3;
  localparam int K_MINUS  = 4;
  localparam int DW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic {VIEW = 1'b0, EDIT = 1'b1} state_t;

  state_t        state, state_nx;
  logic [1:0]    screen_nx;
  logic [2:0]    pos_nx;
  logic [2:0]    first_pos, last_pos;
  logic          restart;
  logic [4:0]    raw, stable, stable_q, press;
  logic [DW-1:0] db_cnt [5];
  logic [BW-1:0] blink_cnt;
  logic          lock, lock_nx;
  logic [1:0]    rep_pulse;

  assign raw   = {KeyMinus, KeyPlus, KeyNext, KeyEdit, KeyScreen};
  assign press = stable_q & ~stable;

  // Stable value flips only after DEBOUNCE consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable   <= '1;
      stable_q <= '1;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      stable_q <= stable;
      for (int i = 0; i < 5; i++) begin
        if (raw[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
          stable[i] <= raw[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    first_pos = 3'd2;
    last_pos  = 3'd7;
    case (screen)
      2'd1:       begin first_pos = 3'd0; last_pos = 3'd7; end
      2'd2, 2'd3: begin first_pos = 3'd2; last_pos = 3'd5; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= VIEW;
      screen  <= '0;
      EditPos <= '0;
    end else begin
      state   <= state_nx;
      screen  <= screen_nx;
      EditPos <= pos_nx;
    end
  end

  // Only the highest-priority press acts, even when its own action is ignored.
  always_comb begin
    state_nx  = state;
    screen_nx = screen;
    pos_nx    = EditPos;
    restart   = 1'b0;
    if (press[K_EDIT]) begin
      if (stable[K_PLUS] && stable[K_MINUS]) begin
        if (state == VIEW) begin
          state_nx = EDIT;
          pos_nx   = first_pos;
          restart  = 1'b1;
        end else begin
          state_nx = VIEW;
          pos_nx   = 3'd0;
        end
      end
    end else if (press[K_NEXT]) begin
      if (state == EDIT) begin
        pos_nx  = (EditPos == last_pos) ? first_pos : EditPos + 3'd1;
        restart = 1'b1;
      end
    end else if (press[K_SCREEN]) begin
      if (state == VIEW) screen_nx = screen + 2'd1;
    end
  end

  assign EditMode = (state == EDIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      Blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (state_nx != EDIT) begin
      Blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (restart) begin
      Blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      Blink     <= ~Blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

`ifdef EDIT_AUTO_REPEAT_EN
  localparam int RW = $clog2(HOLD_CYCLES + REPEAT_CYCLES);

  for (genvar k = 0; k < 2; k++) begin : g_rep
    logic [RW-1:0] cnt, cnt_nx;
    logic          held;
    assign held   = (state == EDIT) & ~stable[K_PLUS + k];
    assign cnt_nx = !held ? '0 :
                    (cnt == RW'(HOLD_CYCLES + REPEAT_CYCLES - 1)) ? RW'(HOLD_CYCLES) :
                    cnt + RW'(1);
    assign rep_pulse[k] = held & (cnt_nx == RW'(HOLD_CYCLES));
    always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else       cnt <= cnt_nx;
    end
  end
`else
  // Pure level keys; the repeat timing only matters when auto-repeat is built in.
  assign rep_pulse = {2{(HOLD_CYCLES < 0) || (REPEAT_CYCLES < 0)}};
`endif

  // Once both keys are down, hold both outputs released until both keys are up.
  assign lock_nx = (lock | (~stable[K_PLUS] & ~stable[K_MINUS])) &
                   ~(stable[K_PLUS] & stable[K_MINUS]);

  always_ff @(posedge clk) begin
    if (reset) begin
      lock        <= 1'b0;
      KeyPlusOut  <= 1'b1;
      KeyMinusOut <= 1'b1;
    end else begin
      lock        <= lock_nx;
      KeyPlusOut  <= (state != EDIT) | lock_nx | stable[K_PLUS]  | rep_pulse[0];
      KeyMinusOut <= (state != EDIT) | lock_nx | stable[K_MINUS] | rep_pulse[1];
    end
  end

endmodule

// File: tb/tb_edit_sequencer.sv
// tb/tb_edit_sequencer.sv - randomized bench for edit_sequencer against a behavioural key/menu model
module tb_edit_sequencer;

  localparam int D    = 16;
  localparam int HOLD = 512;
  localparam int REP  = 64;
  localparam int BH   = 256;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] raw   = 5'h1f;   // 0 screen, 1 edit, 2 next, 3 plus, 4 minus
  logic [1:0] screen;
  logic       EditMode;
  logic [2:0] EditPos;
  logic       KeyPlusOut, KeyMinusOut, Blink;

  int checks = 0;
  int errors = 0;

  edit_sequencer #(.DEBOUNCE(D), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .BLINK_HALF(BH)) dut (
    .clk(clk), .reset(reset),
    .KeyScreen(raw[0]), .KeyEdit(raw[1]), .KeyNext(raw[2]), .KeyPlus(raw[3]), .KeyMinus(raw[4]),
    .screen(screen), .EditMode(EditMode), .EditPos(EditPos),
    .KeyPlusOut(KeyPlusOut), .KeyMinusOut(KeyMinusOut), .Blink(Blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw history windows, menu rules, and time since the last cursor restart.
  int  first_of [4];
  int  last_of  [4];
  bit  hist [5][$];
  bit  m_st [5];
  bit  m_pr [5];
  int  m_screen, m_pos, m_since;
  bit  m_edit, m_blink, m_lock, m_plus, m_minus;
  int  m_held [2];
  bit  was_edit, restart, all_diff;
  bit  pulse [2];

  initial begin
    first_of = '{2, 0, 2, 2};
    last_of  = '{7, 7, 5, 5};
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        m_st[i] = 1'b1;
        m_pr[i] = 1'b0;
        hist[i].delete();
      end
      m_screen = 0; m_pos = 0; m_edit = 0; m_blink = 0; m_since = 0;
      m_lock = 0; m_plus = 1; m_minus = 1; m_held[0] = 0; m_held[1] = 0;
    end else begin
      was_edit = m_edit;
      restart  = 1'b0;
      if (m_pr[1]) begin
        if (m_st[3] && m_st[4]) begin
          if (!m_edit) begin m_edit = 1; m_pos = first_of[m_screen]; restart = 1; end
          else begin m_edit = 0; m_pos = 0; end
        end
      end else if (m_pr[2]) begin
        if (m_edit) begin
          m_pos = (m_pos == last_of[m_screen]) ? first_of[m_screen] : m_pos + 1;
          restart = 1;
        end
      end else if (m_pr[0]) begin
        if (!m_edit) m_screen = (m_screen + 1) % 4;
      end

      if (!m_st[3] && !m_st[4]) m_lock = 1;
      else if (m_st[3] && m_st[4]) m_lock = 0;
      for (int k = 0; k < 2; k++) begin
        if (was_edit && !m_st[3+k]) m_held[k]++;
        else m_held[k] = 0;
`ifdef EDIT_AUTO_REPEAT_EN
        pulse[k] = (m_held[k] >= HOLD) && ((m_held[k] - HOLD) % REP == 0);
`else
        pulse[k] = 1'b0;
`endif
      end
      m_plus  = !was_edit || m_lock || m_st[3] || pulse[0];
      m_minus = !was_edit || m_lock || m_st[4] || pulse[1];

      if (!m_edit) begin m_blink = 0; m_since = 0; end
      else if (restart) begin m_blink = 1; m_since = 0; end
      else begin m_since++; m_blink = ((m_since / BH) % 2) == 0; end

      for (int i = 0; i < 5; i++) begin
        hist[i].push_back(raw[i]);
        if (hist[i].size() > D) void'(hist[i].pop_front());
        m_pr[i] = 1'b0;
        if (hist[i].size() == D) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++) if (hist[i][j] == m_st[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_st[i] = !m_st[i];
            m_pr[i] = !m_st[i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("screen",      32'(screen),      32'(m_screen));
      check("EditMode",    32'(EditMode),    32'(m_edit));
      check("EditPos",     32'(EditPos),     32'(m_pos));
      check("KeyPlusOut",  32'(KeyPlusOut),  32'(m_plus));
      check("KeyMinusOut", 32'(KeyMinusOut), 32'(m_minus));
      check("Blink",       32'(Blink),       32'(m_blink));
    end
  end

  task automatic hold(input logic [4:0] mask, input int low, input int high);
    raw = raw & ~mask;
    repeat (low) @(negedge clk);
    raw = raw | mask;
    repeat (high) @(negedge clk);
  endtask

  int exp_scr [5];
  int exp_pos [4];
  int highs;
  int r, low, high;
  logic [4:0] m;
  logic [1:0] scr_before;

  initial begin
    exp_scr = '{1, 2, 3, 0, 1};
    exp_pos = '{3, 4, 5, 2};
    repeat (3) @(negedge clk);
    check("reset screen", 32'(screen), 0);
    check("reset EditMode", 32'(EditMode), 0);
    check("reset EditPos", 32'(EditPos), 0);
    check("reset KeyPlusOut", 32'(KeyPlusOut), 1);
    check("reset KeyMinusOut", 32'(KeyMinusOut), 1);
    check("reset Blink", 32'(Blink), 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      hold(5'b00001, 20, 20);
      check("screen step", 32'(screen), 32'(exp_scr[i]));
      check("view EditMode", 32'(EditMode), 0);
    end
    hold(5'b00001, 20, 20);
    check("screen to 2", 32'(screen), 2);

    hold(5'b00010, 20, 20);
    check("enter edit", 32'(EditMode), 1);
    check("edit first pos", 32'(EditPos), 2);
    check("blink on entry", 32'(Blink), 1);
    for (int i = 0; i < 4; i++) begin
      hold(5'b00100, 20, 20);
      check("next pos", 32'(EditPos), 32'(exp_pos[i]));
      check("blink on move", 32'(Blink), 1);
    end

    hold(5'b00110, 20, 20);
    check("edit beats next mode", 32'(EditMode), 0);
    check("edit beats next pos", 32'(EditPos), 0);

    for (int i = 0; i < 3; i++) hold(5'b00001, 10, 10);
    check("bounce ignored", 32'(screen), 2);
    raw[0] = 1'b0;
    repeat (D) @(negedge clk);
    check("debounce edge-1", 32'(screen), 2);
    raw[0] = 1'b1;
    @(negedge clk);
    check("debounce edge", 32'(screen), 3);
    repeat (10) @(negedge clk);

    raw[3] = 1'b0;
    repeat (30) @(negedge clk);
    check("view plus released", 32'(KeyPlusOut), 1);
    raw[3] = 1'b1;
    repeat (20) @(negedge clk);

    hold(5'b00010, 20, 20);
    check("edit on screen 3", 32'(EditMode), 1);
    raw[3] = 1'b0;
    repeat (D) @(negedge clk);
    check("plus latency-1", 32'(KeyPlusOut), 1);
    @(negedge clk);
    check("plus latency", 32'(KeyPlusOut), 0);
    hold(5'b00010, 20, 20);
    check("edit blocked by plus", 32'(EditMode), 1);
    raw[3] = 1'b1;
    repeat (20) @(negedge clk);

    highs = 0;
    raw[4:3] = 2'b00;
    repeat (40) begin
      @(negedge clk);
      if (!KeyPlusOut || !KeyMinusOut) highs++;
    end
    raw[4:3] = 2'b11;
    repeat (20) begin
      @(negedge clk);
      if (!KeyPlusOut || !KeyMinusOut) highs++;
    end
    check("both held lows", 32'(highs), 0);

    raw[3] = 1'b0;
    repeat (D + 1) @(negedge clk);
    highs = 0;
    repeat (700) begin
      @(negedge clk);
      if (KeyPlusOut) highs++;
    end
`ifdef EDIT_AUTO_REPEAT_EN
    check("repeat pulses", 32'(highs), 3);
`else
    check("repeat pulses", 32'(highs), 0);
`endif
    raw[3] = 1'b1;
    repeat (20) @(negedge clk);
    hold(5'b00010, 20, 20);
    check("leave edit", 32'(EditMode), 0);

    for (int it = 0; it < 260; it++) begin
      r = $urandom_range(0, 15);
      case (r)
        0, 1, 2, 3: m = 5'b00001;
        4, 5, 6:    m = 5'b00010;
        7, 8, 9:    m = 5'b00100;
        10, 11:     m = 5'b01000;
        12:         m = 5'b10000;
        13:         m = 5'b11000;
        14:         m = 5'b00110;
        default:    m = 5'($urandom_range(1, 31));
      endcase
      low  = (m[4] || m[3]) ? $urandom_range(1, 90) : $urandom_range(1, 35);
      high = $urandom_range(1, 30);
      if (it == 130) begin
        raw[3] = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        raw = 5'h1f;
      end
      hold(m, low, high);
    end
    raw = 5'h1f;
    repeat (40) @(negedge clk);
    scr_before = screen;
    hold(5'b00010, 20, 20);
    if (EditMode) hold(5'b00010, 20, 20);
    check("final view", 32'(EditMode), 0);
    hold(5'b00001, 20, 20);
    check("final screen step", 32'(screen), 32'(2'(scr_before + 2'd1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
